pixel_gen_ball: RTL and testbench

- Downstream pixel generator for vga_controller.
- Consumes video_on, p_tick, refresh_tick, x and y. Produces the 12-bit RGB for the Basys-style 4:4:4 DAC.
- Renders one square ball on a solid background.
- Moves the ball once per frame on refresh_tick and bounces it off all four screen edges.

---
 rtl/vga_pkg.sv | 51 +++++
 rtl/pixel_gen_ball_if.sv | 11 +
 rtl/ball_rom.sv | 18 +
 rtl/pixel_gen_ball.sv | 87 ++++++++
 tb/tb_pixel_gen_ball.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, colour type and the per-axis bounce step used by pixel_gen_ball.
package vga_pkg;

  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;

  typedef logic [11:0] rgb12;

  localparam rgb12 COLOR_BLACK = 12'h000;
  localparam rgb12 COLOR_RED   = 12'hF00;
  localparam rgb12 COLOR_BLUE  = 12'h00F;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       flip;
  } axis_t;

  // One frame of motion on a single axis; sums are kept in 11 bits so the limit test cannot wrap.
  function automatic axis_t step_axis(input logic [9:0] pos, input logic dir,
                                      input logic [10:0] limit, input logic [10:0] vel);
    axis_t      r;
    logic [10:0] nxt;
    r.pos  = pos;
    r.dir  = dir;
    r.flip = 1'b0;
    nxt    = {1'b0, pos} + vel;
    if (dir == DIR_POS) begin
      if (nxt >= limit) begin
        r.pos  = limit[9:0];
        r.dir  = DIR_NEG;
        r.flip = 1'b1;
      end else begin
        r.pos = nxt[9:0];
      end
    end else begin
      if ({1'b0, pos} <= vel) begin
        r.pos  = '0;
        r.dir  = DIR_POS;
        r.flip = 1'b1;
      end else begin
        r.pos = pos - vel[9:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pixel_gen_ball_if.sv
// Video timing bundle from vga_controller (master) to the pixel generator (slave).
interface pixel_gen_ball_if;
  logic       video_on;
  logic       p_tick;
  logic       refresh_tick;
  logic [9:0] x;
  logic [9:0] y;

  modport master (output video_on, p_tick, refresh_tick, x, y);
  modport slave  (input  video_on, p_tick, refresh_tick, x, y);
endinterface

// File: rtl/ball_rom.sv
// 8x8 circular ball mask: one row per address, bit n set when column n is inside the circle.
module ball_rom (
  input  logic [2:0] row,
  output logic [7:0] col_bits
);

  always_comb begin
    col_bits = 8'h00;
    case (row)
      3'd0:    col_bits = 8'h3C;
      3'd1:    col_bits = 8'h7E;
      3'd6:    col_bits = 8'h7E;
      3'd7:    col_bits = 8'h3C;
      default: col_bits = 8'hFF;
    endcase
  end

endmodule

// File: rtl/pixel_gen_ball.sv
// Bouncing-ball pixel generator behind vga_controller; registered 12-bit RGB.
// Define ROUND_BALL_EN for a round ball (masked by ball_rom, needs BALL_SIZE == 8).
module pixel_gen_ball #(
  parameter int            H_DISPLAY  = vga_pkg::H_DISPLAY,
  parameter int            V_DISPLAY  = vga_pkg::V_DISPLAY,
  parameter int            BALL_SIZE  = 8,
  parameter int            BALL_VEL   = 2,
  parameter vga_pkg::rgb12 BALL_COLOR = vga_pkg::COLOR_RED,
  parameter vga_pkg::rgb12 BG_COLOR   = vga_pkg::COLOR_BLUE
) (
  input  logic            clk_100MHz,
  input  logic            reset_n,
  pixel_gen_ball_if.slave vid,
  input  logic            enable,
  output vga_pkg::rgb12   rgb,
  output logic [9:0]      ball_x,
  output logic [9:0]      ball_y,
  output logic            bounce
);
  import vga_pkg::*;

  localparam logic [10:0] X_LIMIT = 11'(H_DISPLAY - BALL_SIZE);
  localparam logic [10:0] Y_LIMIT = 11'(V_DISPLAY - BALL_SIZE);
  localparam logic [10:0] VEL     = 11'(BALL_VEL);
  localparam logic [10:0] SIZE    = 11'(BALL_SIZE);
  localparam logic [9:0]  X_HOME  = 10'((H_DISPLAY - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_HOME  = 10'((V_DISPLAY - BALL_SIZE) / 2);

  logic  dir_x, dir_y;
  axis_t nx, ny;
  logic  in_x, in_y, hit;

  always_comb begin
    nx = step_axis(ball_x, dir_x, X_LIMIT, VEL);
    ny = step_axis(ball_y, dir_y, Y_LIMIT, VEL);
  end

  // Both axes step together once per frame; bounce is a single pulse even at a corner.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      ball_x <= X_HOME;
      ball_y <= Y_HOME;
      dir_x  <= DIR_POS;
      dir_y  <= DIR_POS;
      bounce <= 1'b0;
    end else if (vid.refresh_tick && enable) begin
      ball_x <= nx.pos;
      ball_y <= ny.pos;
      dir_x  <= nx.dir;
      dir_y  <= ny.dir;
      bounce <= nx.flip | ny.flip;
    end else begin
      bounce <= 1'b0;
    end
  end

  assign in_x = ({1'b0, vid.x} >= {1'b0, ball_x}) && ({1'b0, vid.x} < ({1'b0, ball_x} + SIZE));
  assign in_y = ({1'b0, vid.y} >= {1'b0, ball_y}) && ({1'b0, vid.y} < ({1'b0, ball_y} + SIZE));

`ifdef ROUND_BALL_EN
  logic [2:0] col_off, row_off;
  logic [7:0] mask_row;

  // Low three bits of the offset are enough because the mask is only consulted inside the box.
  assign col_off = vid.x[2:0] - ball_x[2:0];
  assign row_off = vid.y[2:0] - ball_y[2:0];

  ball_rom u_ball_rom (
    .row      (row_off),
    .col_bits (mask_row)
  );

  assign hit = in_x && in_y && mask_row[col_off];
`else
  assign hit = in_x && in_y;
`endif

  // Rendering uses the ball position before any same-cycle frame update.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      rgb <= COLOR_BLACK;
    end else if (vid.p_tick) begin
      rgb <= vid.video_on ? (hit ? BALL_COLOR : BG_COLOR) : COLOR_BLACK;
    end
  end

endmodule

// File: tb/tb_pixel_gen_ball.sv
// Scoreboard bench for pixel_gen_ball: stimulus pushes model expectations, a monitor pops and compares.
module tb_pixel_gen_ball;

  localparam int X_LIM  = 640 - 8;
  localparam int Y_LIM  = 480 - 8;
  localparam int X_HOME = 316;
  localparam int Y_HOME = 236;

  typedef struct {
    int bx;
    int by;
    bit bnc;
  } mot_t;

  logic        clk_100MHz;
  logic        reset_n;
  logic        enable;
  logic [11:0] rgb;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic        bounce;

  pixel_gen_ball_if vif ();

  pixel_gen_ball dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .vid        (vif),
    .enable     (enable),
    .rgb        (rgb),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .bounce     (bounce)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: signed velocity per axis, clamp-and-reverse at the edges
  int mx, my, mvx, mvy;
  logic [11:0] rgb_q[$];
  mot_t        mot_q[$];
  logic [11:0] last_rgb;
  int          cur_bx, cur_by;

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic move_axis(inout int p, inout int v, input int lim, output bit f);
    int n;
    n = p + v;
    f = 1'b0;
    if (n >= lim) begin
      p = lim; v = -2; f = 1'b1;
    end else if (n <= 0) begin
      p = 0; v = 2; f = 1'b1;
    end else begin
      p = n;
    end
  endtask

  task automatic model_step(output bit f);
    bit fx, fy;
    move_axis(mx, mvx, X_LIM, fx);
    move_axis(my, mvy, Y_LIM, fy);
    f = fx | fy;
  endtask

  function automatic logic [11:0] exp_pixel(input bit vo, input int px, input int py);
    bit hit;
    if (!vo) return 12'h000;
    hit = (px >= mx) && (px < mx + 8) && (py >= my) && (py < my + 8);
`ifdef ROUND_BALL_EN
    if (hit) begin
      int r, c;
      r = 2 * (py - my) - 7;
      c = 2 * (px - mx) - 7;
      hit = (r * r + c * c) <= 64;
    end
`endif
    return hit ? 12'hF00 : 12'h00F;
  endfunction

  task automatic apply_stimulus(input bit vo, input bit pt, input bit rt, input bit en,
                                input logic [9:0] xx, input logic [9:0] yy);
    bit f;
    mot_t m;
    @(negedge clk_100MHz);
    vif.video_on     = vo;
    vif.p_tick       = pt;
    vif.refresh_tick = rt;
    vif.x            = xx;
    vif.y            = yy;
    enable           = en;
    if (pt) rgb_q.push_back(exp_pixel(vo, int'(xx), int'(yy)));
    if (rt) begin
      f = 1'b0;
      if (en) model_step(f);
      m.bx = mx; m.by = my; m.bnc = f;
      mot_q.push_back(m);
    end
  endtask

  task automatic random_cycle(input bit rt, input bit en);
    logic [9:0] xx, yy;
    xx = 10'(mx + int'($urandom_range(0, 11)) - 2);
    yy = 10'(my + int'($urandom_range(0, 11)) - 2);
    if ($urandom_range(0, 3) == 0) xx = 10'($urandom_range(0, 1023));
    if ($urandom_range(0, 3) == 0) yy = 10'($urandom_range(0, 1023));
    apply_stimulus(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), rt, en, xx, yy);
  endtask

  task automatic reset_sequence();
    @(negedge clk_100MHz);
    vif.video_on     = 1'b0;
    vif.p_tick       = 1'b0;
    vif.refresh_tick = 1'b0;
    reset_n          = 1'b0;
    #1;
    check_output("reset_rgb", rgb, 12'h000);
    check_output("reset_ball_x", ball_x, X_HOME);
    check_output("reset_ball_y", ball_y, Y_HOME);
    check_output("reset_bounce", bounce, 0);
    rgb_q.delete();
    mot_q.delete();
    mx = X_HOME; my = Y_HOME; mvx = 2; mvy = 2;
    last_rgb = 12'h000;
    cur_bx = X_HOME; cur_by = Y_HOME;
    @(negedge clk_100MHz);
    reset_n = 1'b1;
  endtask

  // Monitor: rgb is presented the cycle after p_tick, motion the cycle after refresh_tick
  initial begin
    bit f_p, f_r, live;
    mot_t m;
    logic [11:0] e;
    forever begin
      @(posedge clk_100MHz);
      f_p  = vif.p_tick;
      f_r  = vif.refresh_tick;
      live = reset_n;
      #1;
      if (live && reset_n) begin
        if (f_p) begin
          if (rgb_q.size() == 0) begin
            check_output("rgb_queue_underflow", 1, 0);
          end else begin
            e = rgb_q.pop_front();
            last_rgb = e;
            check_output("rgb", rgb, e);
          end
        end else begin
          check_output("rgb_hold", rgb, last_rgb);
        end
        if (f_r) begin
          if (mot_q.size() == 0) begin
            check_output("motion_queue_underflow", 1, 0);
          end else begin
            m = mot_q.pop_front();
            cur_bx = m.bx; cur_by = m.by;
            check_output("ball_x", ball_x, m.bx);
            check_output("ball_y", ball_y, m.by);
            check_output("bounce", bounce, m.bnc);
          end
        end else begin
          check_output("ball_x_still", ball_x, cur_bx);
          check_output("ball_y_still", ball_y, cur_by);
          check_output("bounce_idle", bounce, 0);
        end
        check_output("ball_x_range", ball_x <= X_LIM, 1);
      end
    end
  end

  initial begin
    reset_n          = 1'b0;
    enable           = 1'b0;
    vif.video_on     = 1'b0;
    vif.p_tick       = 1'b0;
    vif.refresh_tick = 1'b0;
    vif.x            = '0;
    vif.y            = '0;
    mx = X_HOME; my = Y_HOME; mvx = 2; mvy = 2;
    last_rgb = 12'h000;
    cur_bx = X_HOME; cur_by = Y_HOME;
    reset_sequence();

    apply_stimulus(1, 1, 0, 1, 10'd316, 10'd236);
    apply_stimulus(1, 0, 0, 1, 10'd0, 10'd0);
`ifdef ROUND_BALL_EN
    check_output("corner_pixel_bg", rgb, 12'h00F);
    apply_stimulus(1, 1, 0, 1, 10'd319, 10'd239);
    apply_stimulus(1, 0, 0, 1, 10'd0, 10'd0);
    check_output("centre_pixel_ball", rgb, 12'hF00);
`else
    check_output("hit_316_236", rgb, 12'hF00);
`endif
    apply_stimulus(1, 1, 0, 1, 10'd324, 10'd236);
    apply_stimulus(1, 0, 0, 1, 10'd316, 10'd236);
    check_output("miss_324", rgb, 12'h00F);
    apply_stimulus(1, 0, 0, 1, 10'd316, 10'd236);
    check_output("hold_no_ptick", rgb, 12'h00F);
    apply_stimulus(0, 1, 0, 1, 10'd316, 10'd236);
    apply_stimulus(0, 0, 0, 1, 10'd0, 10'd0);
    check_output("blank_black", rgb, 12'h000);

    apply_stimulus(0, 0, 1, 1, 10'd0, 10'd0);
    apply_stimulus(0, 0, 0, 1, 10'd0, 10'd0);
    check_output("move_x", ball_x, 318);
    check_output("move_y", ball_y, 238);
    check_output("move_bounce", bounce, 0);
    apply_stimulus(0, 0, 1, 0, 10'd0, 10'd0);
    apply_stimulus(0, 0, 0, 0, 10'd0, 10'd0);
    check_output("frozen_x", ball_x, 318);
    check_output("frozen_y", ball_y, 238);
    check_output("frozen_bounce", bounce, 0);

    reset_sequence();
    for (int t = 1; t <= 160; t++) begin
      random_cycle(1, 1);
      random_cycle(0, 1);
      if (t == 118) begin
        check_output("bottom_y", ball_y, 472);
        check_output("bottom_bounce", bounce, 1);
      end
      if (t == 119) begin
        check_output("bottom_return_y", ball_y, 470);
        check_output("bottom_after_bounce", bounce, 0);
      end
      if (t == 158) begin
        check_output("right_x", ball_x, 632);
        check_output("right_bounce", bounce, 1);
      end
      if (t == 159) begin
        check_output("right_return_x", ball_x, 630);
        check_output("right_after_bounce", bounce, 0);
      end
    end

    reset_sequence();
    for (int t = 1; t <= 9322; t++) begin
      random_cycle(1, 1);
      random_cycle(0, 1);
      if (t == 9322) begin
        check_output("corner_x", ball_x, 0);
        check_output("corner_y", ball_y, 0);
        check_output("corner_bounce", bounce, 1);
      end
    end
    random_cycle(0, 1);
    check_output("corner_single_pulse", bounce, 0);

    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) reset_sequence();
      random_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    apply_stimulus(0, 0, 0, 1, 10'd0, 10'd0);
    apply_stimulus(0, 0, 0, 1, 10'd0, 10'd0);
    apply_stimulus(0, 0, 0, 1, 10'd0, 10'd0);
    check_output("queue_drain", rgb_q.size() + mot_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
